// File: rtl/fp_pack_obuf.sv
// Packs unpacked FP32 multiplier fields into IEEE-754 words with class flags and buffers them in a FIFO.
// Latency 1 cycle from in_valid to out_valid when empty; no upstream backpressure, so inputs arriving when full are dropped and flagged.
module fp_pack_obuf #(
    parameter int DEPTH        = 4,
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [22:0]                in_man,
    input  logic [7:0]                 in_exp,
    input  logic                       in_sign,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [3:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic [15:0]                res_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic denorm;
    } flags_t;

    typedef struct packed {
        flags_t      flags;
        logic [31:0] word;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          pkt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     res_cnt_q, res_cnt_d;

    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    // Classification and packing of the incoming fields
    always_comb begin
        pkt_d       = '0;
        pkt_d.word  = {in_sign, in_exp, in_man};
        if (in_exp == 8'hFF) begin
            if (in_man != 23'd0) begin
                pkt_d.flags.nan = 1'b1;
                pkt_d.word      = 32'h7FC0_0000;
            end else begin
                pkt_d.flags.inf = 1'b1;
                pkt_d.word      = {in_sign, 8'hFF, 23'd0};
            end
        end else if (in_exp == 8'h00) begin
            if (in_man == 23'd0) begin
                pkt_d.flags.zero = 1'b1;
                pkt_d.word       = {in_sign, 31'd0};
            end else begin
                pkt_d.flags.denorm = 1'b1;
                if (FLUSH_DENORM) begin
                    pkt_d.word = {in_sign, 31'd0};
                end
            end
        end
    end

    // Push is allowed into a full FIFO only when the head leaves in the same cycle
    always_comb begin
        full = (count_q == CW'(DEPTH));
        pop  = (count_q != '0) && out_ready;
        push = in_valid && (!full || pop);
        drop = in_valid && full && !pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        res_cnt_d  = res_cnt_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
            res_cnt_d = res_cnt_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A drop wins over a concurrent clear
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            res_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

    // Storage is cleared on reset so the head reads zero while empty after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= pkt_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q].word;
    assign out_flags = mem_q[rd_ptr_q].flags;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_fp_pack_obuf.sv
// Bench for fp_pack_obuf: vector table, directed corner sequences and a random run against a queue model.
module tb_fp_pack_obuf;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [22:0] in_man;
    logic [7:0]  in_exp;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_flags;
    logic [2:0]  count;
    logic        overflow;
    logic        clr_ovf;
    logic [15:0] res_cnt;

    fp_pack_obuf #(.DEPTH(DEPTH), .FLUSH_DENORM(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_man(in_man), .in_exp(in_exp),
        .in_sign(in_sign), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .count(count), .overflow(overflow), .clr_ovf(clr_ovf),
        .res_cnt(res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: queue of {flags, word}
    logic [35:0] mq[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_res = 16'd0;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [31:0] w;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [35:0] ref_pack(input logic s, input logic [7:0] e, input logic [22:0] m);
        if (e == 8'hFF) return (m != 0) ? {4'b1000, 32'h7FC00000} : {4'b0100, s, 8'hFF, 23'd0};
        if (e == 8'h00) return (m == 0) ? {4'b0010, s, 31'd0} : {4'b0001, s, 31'd0};
        return {4'b0000, s, e, m};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic v, input logic [31:0] w, input logic rdy,
                              input logic clr, input logic r);
        logic pop, full;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_res = 16'd0;
            return;
        end
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (v && (!full || pop)) begin
            mq.push_back(ref_pack(w[31], w[30:23], w[22:0]));
            m_res = m_res + 16'd1;
        end
        if (v && full && !pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    // One clock: drive, advance model at the edge, compare 1 time unit later
    task automatic cyc(input logic v, input logic [31:0] w, input logic rdy,
                       input logic clr, input logic r);
        in_valid  = v;
        in_sign   = w[31];
        in_exp    = w[30:23];
        in_man    = w[22:0];
        out_ready = rdy;
        clr_ovf   = clr;
        rst       = r;
        @(posedge clk);
        model_step(v, w, rdy, clr, r);
        #1;
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("res_cnt", 32'(res_cnt), 32'(m_res));
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0][31:0]);
            chk("out_flags", 32'(out_flags), 32'(mq[0][35:32]));
        end
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'd0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  e;
        logic [31:0] seq_w [6];

        tbl[0] = '{1'b0, 8'h7F, 23'h000000, 32'h3F800000, 4'b0000};
        tbl[1] = '{1'b1, 8'hFF, 23'h000001, 32'h7FC00000, 4'b1000};
        tbl[2] = '{1'b0, 8'hFF, 23'h400000, 32'h7FC00000, 4'b1000};
        tbl[3] = '{1'b1, 8'hFF, 23'h000000, 32'hFF800000, 4'b0100};
        tbl[4] = '{1'b0, 8'hFF, 23'h000000, 32'h7F800000, 4'b0100};
        tbl[5] = '{1'b1, 8'h00, 23'h000000, 32'h80000000, 4'b0010};
        tbl[6] = '{1'b0, 8'h00, 23'h000005, 32'h00000000, 4'b0001};
        tbl[7] = '{1'b1, 8'h00, 23'h7FFFFF, 32'h80000000, 4'b0001};
        tbl[8] = '{1'b0, 8'h80, 23'h123456, 32'h40123456, 4'b0000};
        tbl[9] = '{1'b1, 8'hFE, 23'h7FFFFF, 32'hFF7FFFFF, 4'b0000};

        // Reset state
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_flags", 32'(out_flags), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_res", 32'(res_cnt), 32'd0);

        // Packing table: one push per cycle with the consumer always ready
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, {tbl[i].s, tbl[i].e, tbl[i].m}, 1'b1, 1'b0, 1'b0);
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_data", out_data, tbl[i].w);
            chk("tbl_flags", 32'(out_flags), 32'(tbl[i].f));
            if (i == 0) chk("first_res_cnt", 32'(res_cnt), 32'd1);
        end
        idle(1'b1);

        // Fill and overflow, then drain in order
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h3F800000 + 32'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_res", 32'(res_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", out_data, 32'h3F800000 + 32'(i));
            idle(1'b1);
        end
        chk("drained_valid", 32'(out_valid), 32'd0);
        idle(1'b1);
        chk("no_underflow", 32'(count), 32'd0);

        // Full with simultaneous push and pop, then clear racing a drop
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) seq_w[i] = 32'h40000000 + 32'(i * 16);
        for (int i = 0; i < 4; i++) cyc(1'b1, seq_w[i], 1'b0, 1'b0, 1'b0);
        cyc(1'b1, seq_w[4], 1'b1, 1'b0, 1'b0);
        chk("pp_full_count", 32'(count), 32'd4);
        chk("pp_full_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, seq_w[5], 1'b0, 1'b1, 1'b0);
        chk("clr_vs_drop", 32'(overflow), 32'd1);
        for (int i = 1; i < 5; i++) begin
            chk("pp_order", out_data, seq_w[i]);
            idle(1'b1);
        end
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Simultaneous push and pop at count 1
        cyc(1'b1, 32'h41000000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h41100000, 1'b1, 1'b0, 1'b0);
        chk("pp_one_count", 32'(count), 32'd1);
        chk("pp_one_data", out_data, 32'h41100000);
        idle(1'b1);

        // Reset mid-operation overrides a concurrent push
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h42000000, 1'b0, 1'b0, 1'b0);
        chk("mid_count3", 32'(count), 32'd3);
        cyc(1'b1, 32'h42100000, 1'b1, 1'b1, 1'b1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_res", 32'(res_cnt), 32'd0);
        cyc(1'b1, 32'h42200000, 1'b0, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_data", out_data, 32'h42200000);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       e = 8'h00;
                1:       e = 8'hFF;
                default: e = 8'($urandom);
            endcase
            w = {1'($urandom), e, ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom)};
            cyc(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 199) == 0));
        end

        // Counter wrap
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65535; i++) cyc(1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0);
        chk("res_cnt_max", 32'(res_cnt), 32'h0000FFFF);
        cyc(1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0);
        chk("res_cnt_wrap", 32'(res_cnt), 32'd0);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_pack_obuf.md
FP_PACK_OBUF -- requirements
Module: fp_pack_obuf

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter FLUSH_DENORM, default 1: 1 = flush denormals to signed zero; 0 = pass through.

Ports (name, direction, width, meaning):
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: the multiplier result fields are valid this cycle. There is no upstream backpressure.
REQ-006 SHALL have ports in_man (input, 23), in_exp (input, 8) and in_sign (input, 1): the unpacked multiplier result fields.
REQ-007 SHALL have port out_valid, output, 1: the FIFO head entry is available.
REQ-008 SHALL have port out_ready, input, 1: the consumer accepts the head entry.
REQ-009 SHALL have port out_data, output, 32: the packed IEEE-754 single-precision word at the FIFO head.
REQ-010 SHALL have port out_flags, output, 4: {nan, inf, zero, denorm} for the head entry.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1: current FIFO occupancy.
REQ-012 SHALL have port overflow, output, 1: sticky flag; an input was dropped because the FIFO was full.
REQ-013 SHALL have port clr_ovf, input, 1: clears overflow.
REQ-014 SHALL have port res_cnt, output, 16: running count of accepted results, wrapping modulo 2^16.

Function
Packing and classification (combinational on inputs, applied before storage):
REQ-015 SHALL set nan=1 when in_exp==8'hFF and in_man!=0; the stored word is then 32'h7FC00000 regardless of in_sign.
REQ-016 SHALL set inf=1 when in_exp==8'hFF and in_man==0; the stored word is {in_sign, 8'hFF, 23'h0}.
REQ-017 SHALL set zero=1 when in_exp==0 and in_man==0; the stored word is {in_sign, 31'h0}.
REQ-018 SHALL set denorm=1 when in_exp==0 and in_man!=0. The stored word is {in_sign, 31'h0} if FLUSH_DENORM=1, otherwise {in_sign, in_exp, in_man}.
REQ-019 SHALL store {in_sign, in_exp, in_man} with all flags 0 for every other input.

FIFO:
REQ-020 SHALL compute push = in_valid and (count<DEPTH or pop), where pop = out_valid and out_ready.
REQ-021 SHALL accept a push in the cycle in_valid is high; the entry is visible on out_valid/out_data at the next rising edge, giving a latency of 1 cycle when the FIFO is empty.
REQ-022 SHALL present entries in strict arrival order, with out_data/out_flags driven from storage (first-word fall-through).
REQ-023 SHALL hold out_valid=1 exactly when count!=0.
REQ-024 SHALL hold out_data/out_flags stable while out_valid=1 and out_ready=0.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL, on simultaneous push and pop, leave count unchanged; this applies when full and when count==1.
REQ-027 SHALL ignore out_ready when count==0; count does not underflow.
REQ-028 SHALL drop in_valid when full with no pop and set overflow=1; count, contents and res_cnt are unchanged.
REQ-029 SHALL give set priority to overflow: if clr_ovf and a drop occur in the same cycle, overflow=1.
REQ-030 SHALL clear overflow on clr_ovf when no drop occurs in that cycle.
REQ-031 SHALL increment res_cnt by 1 per accepted push, wrapping 16'hFFFF to 16'h0000; dropped inputs are not counted.

Reset
REQ-032 SHALL, on rst=1 at a rising edge, set count=0, out_valid=0, out_data=0, out_flags=0, overflow=0, res_cnt=0 and both pointers to 0.
REQ-033 SHALL let rst override any concurrent push, pop or clr_ovf; in-flight entries are discarded.
REQ-034 SHALL accept a push in the first cycle after rst deasserts.

Verification
REQ-035 Normal value: in_sign=0, in_exp=8'h7F, in_man=0, out_ready=1 -> next cycle out_valid=1, out_data=32'h3F800000, out_flags=0000, res_cnt=1.
REQ-036 Specials: sign1/FF/man1 -> 32'h7FC00000, flags=1000. Sign1/FF/0 -> 32'hFF800000, flags=0100. Sign0/00/man5 with FLUSH_DENORM=1 -> 32'h00000000, flags=0001.
REQ-037 Fill and overflow: DEPTH=4, out_ready=0, 5 consecutive pushes -> count=4, overflow=1, res_cnt=4. Raising out_ready then drains the first 4 words in order.
REQ-038 Full with simultaneous push and pop: count stays 4, overflow stays 0, and the new word emerges after the 3 older ones. Then clr_ovf together with a drop -> overflow remains 1.
REQ-039 Reset mid-operation: count=3, assert rst for 1 cycle -> all outputs 0. A push in the next cycle yields out_valid=1 one cycle later with count=1.
REQ-040 Counter wrap: preload via 65536 pushes drained at out_ready=1 -> res_cnt returns to 16'h0000.
